// File: rtl/skipring_pkg.sv
// Shared constants for the multi-channel clock-pulse swallower.
package skipring_pkg;

    localparam logic MODE_PAT  = 1'b0;
    localparam logic MODE_FRAC = 1'b1;

    localparam int NCH_DEF = 4;
    localparam int LEN_DEF = 16;

    // Reset period covers the whole pattern register.
    function automatic int unsigned plen_rst(input int unsigned len);
        return len - 1;
    endfunction

endpackage

// File: rtl/skipring_ch.sv
// One swallower channel: pattern/fraction state, advanced on the falling edge
// so the gate never changes while the source clock is high.
module skipring_ch
    import skipring_pkg::*;
#(
    parameter int LEN = LEN_DEF,
    parameter int LW  = $clog2(LEN)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          ld_i,
    input  logic [LEN-1:0] ld_mask_i,
    input  logic [LW-1:0]  ld_len_i,
    input  logic [LW-1:0]  ld_ph_i,
    input  logic          ld_mode_i,
    output logic          gate_o,
    output logic          sync_o,
    output logic [LW-1:0] ph_o
);

    localparam logic [LW-1:0] PLEN_RST = LW'(plen_rst(LEN));

    logic [LEN-1:0] mask_q, mask_d;
    logic [LW-1:0]  plen_q, plen_d;
    logic           mode_q, mode_d;
    logic [LW-1:0]  p_q, p_d;
    logic [LEN-1:0] acc_q, acc_d;
    logic           gate_q, gate_d;
    logic           sync_q, sync_d;

    logic [LEN:0]   sum;
    logic [LW-1:0]  p_inc;
    logic [LW-1:0]  ld_p;

    assign sum   = {1'b0, acc_q} + {1'b0, mask_q};
    assign p_inc = (p_q == plen_q) ? '0 : p_q + 1'b1;
    // Out-of-range start phase falls back to phase 0.
    assign ld_p  = (ld_ph_i > ld_len_i) ? '0 : ld_ph_i;

    always_comb begin
        mask_d = mask_q;
        plen_d = plen_q;
        mode_d = mode_q;
        p_d    = p_q;
        acc_d  = acc_q;
        gate_d = 1'b0;
        sync_d = 1'b0;
        if (ld_i) begin
            mask_d = ld_mask_i;
            plen_d = ld_len_i;
            mode_d = ld_mode_i;
            p_d    = ld_p;
            acc_d  = '0;
            if (ld_mode_i == MODE_PAT) begin
                gate_d = en_i & ld_mask_i[ld_p];
                sync_d = en_i & (ld_p == '0);
            end
        end else if (en_i) begin
            if (mode_q == MODE_PAT) begin
                p_d    = p_inc;
                gate_d = mask_q[p_inc];
                sync_d = (p_inc == '0);
            end else begin
                acc_d  = sum[LEN-1:0];
                gate_d = sum[LEN];
                sync_d = sum[LEN];
                p_d    = sum[LEN-1 -: LW];
            end
        end
    end

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mask_q <= '0;
            plen_q <= PLEN_RST;
            mode_q <= MODE_PAT;
            p_q    <= '0;
            acc_q  <= '0;
            gate_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            mask_q <= mask_d;
            plen_q <= plen_d;
            mode_q <= mode_d;
            p_q    <= p_d;
            acc_q  <= acc_d;
            gate_q <= gate_d;
            sync_q <= sync_d;
        end
    end

    assign gate_o = gate_q;
    assign sync_o = sync_q;
    assign ph_o   = p_q;

endmodule

// File: rtl/skipring_mc.sv
// Multi-channel clock-pulse swallower: samples enables and the load port on
// the rising edge, decodes the target channel and packs per-channel outputs.
module skipring_mc
    import skipring_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int LEN = LEN_DEF,
    parameter int LW  = $clog2(LEN),
    parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              iCLK,
    input  logic              RSTn,
    input  logic [NCH-1:0]    E,
    input  logic              LD,
    input  logic [CW-1:0]     LDCH,
    input  logic [LEN-1:0]    LDMASK,
    input  logic [LW-1:0]     LDLEN,
    input  logic [LW-1:0]     LDPH,
    input  logic              LDMODE,
    output logic              LDACK,
    output logic [NCH-1:0]    oCLK,
    output logic [NCH-1:0]    oSYNC,
    output logic [NCH*LW-1:0] oPH
);

    localparam logic [CW:0] NCH_L = (CW+1)'(NCH);

    logic [NCH-1:0] ereg_q;
    logic           ld_q;
    logic [CW-1:0]  ldch_q;
    logic [LEN-1:0] ldmask_q;
    logic [LW-1:0]  ldlen_q;
    logic [LW-1:0]  ldph_q;
    logic           ldmode_q;
    logic           ack_q;
    logic           ld_ok;
    logic [NCH-1:0] gate;

    always_ff @(posedge iCLK or negedge RSTn) begin
        if (!RSTn) begin
            ereg_q   <= '0;
            ld_q     <= 1'b0;
            ldch_q   <= '0;
            ldmask_q <= '0;
            ldlen_q  <= '0;
            ldph_q   <= '0;
            ldmode_q <= MODE_PAT;
            ack_q    <= 1'b0;
        end else begin
            ereg_q   <= E;
            ld_q     <= LD;
            ldch_q   <= LDCH;
            ldmask_q <= LDMASK;
            ldlen_q  <= LDLEN;
            ldph_q   <= LDPH;
            ldmode_q <= LDMODE;
            ack_q    <= ld_ok;
        end
    end

    // Loads addressed past the last channel are dropped silently.
    assign ld_ok = ld_q && ({1'b0, ldch_q} < NCH_L);
    assign LDACK = ack_q;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        skipring_ch #(.LEN(LEN), .LW(LW)) u_ch (
            .clk_i     (iCLK),
            .rst_ni    (RSTn),
            .en_i      (ereg_q[c]),
            .ld_i      (ld_ok && (ldch_q == CW'(c))),
            .ld_mask_i (ldmask_q),
            .ld_len_i  (ldlen_q),
            .ld_ph_i   (ldph_q),
            .ld_mode_i (ldmode_q),
            .gate_o    (gate[c]),
            .sync_o    (oSYNC[c]),
            .ph_o      (oPH[c*LW +: LW])
        );
        assign oCLK[c] = iCLK & ~gate[c];
    end

endmodule
